// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle on operand magnitudes, with sign correction applied in a final FIX cycle.
module muldiv_unit #(
   parameter  int XLEN  = 32,
   localparam int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            kill,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   // state  | meaning
   // IDLE   | waiting for start
   // CALC   | one multiply/divide iteration per cycle, counter counts down to 0
   // FIX    | sign correction / special-case select, result register loaded
   // DONE   | one-cycle done pulse; a new start may be accepted here
   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0]   hi_q, hi_d;
   logic [XLEN-1:0]   lo_q, lo_d;
   logic [XLEN-1:0]   md_q, md_d;
   logic [2:0]        op_q, op_d;
   logic              neg_q_q, neg_q_d;
   logic              neg_r_q, neg_r_d;
   logic              special_q, special_d;
   logic              div0_q, div0_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic              a_sgn, b_sgn, neg_a, neg_b, special_in;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_sh;
   logic              div_ge;
   logic [XLEN-1:0]   div_diff;
   logic [2*XLEN-1:0] prod, prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix, fix_val;

   // Operand signedness: MUL treated unsigned (low half is sign-agnostic)
   always_comb begin
      a_sgn      = op[2] ? ~op[0] : ((op[1:0] == 2'b01) || (op[1:0] == 2'b10));
      b_sgn      = op[2] ? ~op[0] : (op[1:0] == 2'b01);
      neg_a      = a_sgn & a[XLEN-1];
      neg_b      = b_sgn & b[XLEN-1];
      mag_a      = neg_a ? -a : a;
      mag_b      = neg_b ? -b : b;
      special_in = op[2] && ((b == '0) || (!op[0] && (a == MIN_NEG) && (b == '1)));
   end

   always_comb begin
      mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, md_q} : '0);
      div_sh   = {hi_q, lo_q[XLEN-1]};
      div_ge   = div_sh >= {1'b0, md_q};
      div_diff = div_sh[XLEN-1:0] - md_q;
   end

   always_comb begin
      prod     = {hi_q, lo_q};
      prod_fix = neg_q_q ? -prod : prod;
      quo_fix  = neg_q_q ? -lo_q : lo_q;
      rem_fix  = neg_r_q ? -hi_q : hi_q;
      if (special_q) begin
         // lo_q holds the raw dividend on the special path
         if (op_q[1]) fix_val = div0_q ? lo_q : '0;
         else         fix_val = div0_q ? '1 : lo_q;
      end else if (op_q[2]) begin
         fix_val = op_q[1] ? rem_fix : quo_fix;
      end else begin
         fix_val = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      md_d      = md_q;
      op_d      = op_q;
      neg_q_d   = neg_q_q;
      neg_r_d   = neg_r_q;
      special_d = special_q;
      div0_d    = div0_q;
      result_d  = result_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (!kill && start) begin
               op_d      = op;
               neg_q_d   = neg_a ^ neg_b;
               neg_r_d   = neg_a;
               special_d = special_in;
               div0_d    = (b == '0);
               hi_d      = '0;
               md_d      = op[2] ? mag_b : mag_a;
               if (special_in) begin
                  lo_d    = a;
                  cnt_d   = '0;
                  state_d = S_FIX;
               end else begin
                  lo_d    = op[2] ? mag_a : mag_b;
                  cnt_d   = CNT_W'(XLEN);
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            if (kill) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
               if (op_q[2]) begin
                  hi_d = div_ge ? div_diff : div_sh[XLEN-1:0];
                  lo_d = {lo_q[XLEN-2:0], div_ge};
               end else begin
                  {hi_d, lo_d} = {mul_sum, lo_q[XLEN-1:1]};
               end
               if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            end
         end
         S_FIX: begin
            if (kill) begin
               state_d = S_IDLE;
            end else begin
               result_d = fix_val;
               state_d  = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         md_q      <= '0;
         op_q      <= '0;
         neg_q_q   <= 1'b0;
         neg_r_q   <= 1'b0;
         special_q <= 1'b0;
         div0_q    <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         md_q      <= md_d;
         op_q      <= op_d;
         neg_q_q   <= neg_q_d;
         neg_r_q   <= neg_r_d;
         special_q <= special_d;
         div0_q    <= div0_d;
         result_q  <= result_d;
      end
   end

   assign busy   = (state_q == S_CALC) || (state_q == S_FIX);
   assign done   = (state_q == S_DONE);
   assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: table of hand-computed vectors plus
// sequences for back-to-back issue, kill, reset and ignored starts.
module tb_muldiv_unit;

   localparam int XLEN = 32;
   localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010,
                          OP_MULHU = 3'b011, OP_DIV = 3'b100, OP_DIVU = 3'b101,
                          OP_REM = 3'b110, OP_REMU = 3'b111;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic            kill = 1'b0;
   logic [2:0]      op = '0;
   logic [XLEN-1:0] a = '0;
   logic [XLEN-1:0] b = '0;
   logic            busy, done;
   logic [XLEN-1:0] result;

   int tests = 0;
   int fails = 0;

   muldiv_unit #(.XLEN(XLEN)) dut (
      .clk(clk), .rst(rst), .start(start), .kill(kill), .op(op),
      .a(a), .b(b), .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [2:0] op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int         lat;
   } vec_t;

   vec_t vecs[20];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive a start; returns #1 after the accepting edge
   task automatic start_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output int lat, output int bcnt, output int ovl);
      lat = 0; bcnt = 0; ovl = 0;
      if (busy) bcnt++;
      while (!done && lat < 100) begin
         @(posedge clk); #1;
         lat++;
         if (busy) bcnt++;
         if (busy && done) ovl++;
      end
   endtask

   task automatic count_dones(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         if (done) n++;
      end
   endtask

   initial begin
      int lat, bcnt, ovl, nd;

      vecs[0]  = '{"mul_7_m3",       OP_MUL,    32'h7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
      vecs[1]  = '{"mulh_min_min",   OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33};
      vecs[2]  = '{"mulhu_max_max",  OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
      vecs[3]  = '{"mulhsu_m1_max",  OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
      vecs[4]  = '{"div_m7_2",       OP_DIV,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 33};
      vecs[5]  = '{"rem_m7_2",       OP_REM,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 33};
      vecs[6]  = '{"divu_100_7",     OP_DIVU,   32'd100,      32'd7,        32'd14,       33};
      vecs[7]  = '{"remu_100_7",     OP_REMU,   32'd100,      32'd7,        32'd2,        33};
      vecs[8]  = '{"divu_5_0",       OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1};
      vecs[9]  = '{"remu_5_0",       OP_REMU,   32'd5,        32'd0,        32'd5,        1};
      vecs[10] = '{"div_ovf",        OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
      vecs[11] = '{"rem_ovf",        OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h0,        1};
      vecs[12] = '{"mul_shift",      OP_MUL,    32'h12345678, 32'h10,       32'h23456780, 33};
      vecs[13] = '{"mulh_m1_m1",     OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        33};
      vecs[14] = '{"mulh_m1_2",      OP_MULH,   32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 33};
      vecs[15] = '{"mulhu_min_2",    OP_MULHU,  32'h80000000, 32'h2,        32'h1,        33};
      vecs[16] = '{"div_7_m2",       OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33};
      vecs[17] = '{"rem_7_m2",       OP_REM,    32'd7,        32'hFFFFFFFE, 32'h1,        33};
      vecs[18] = '{"rem_m5_0",       OP_REM,    32'hFFFFFFFB, 32'h0,        32'hFFFFFFFB, 1};
      vecs[19] = '{"div_min_1",      OP_DIV,    32'h80000000, 32'h1,        32'h80000000, 33};

      #1;
      check("rst_busy",   64'(busy),   64'd0);
      check("rst_done",   64'(done),   64'd0);
      check("rst_result", 64'(result), 64'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 20; i++) begin
         start_op(vecs[i].op, vecs[i].a, vecs[i].b);
         wait_done(lat, bcnt, ovl);
         check({vecs[i].name, "_result"}, 64'(result), 64'(vecs[i].exp));
         check({vecs[i].name, "_lat"},    64'(lat),    64'(vecs[i].lat));
         check({vecs[i].name, "_busy"},   64'(bcnt),   64'(vecs[i].lat));
         check({vecs[i].name, "_ovl"},    64'(ovl),    64'd0);
         @(posedge clk); #1;
         check({vecs[i].name, "_done_1cyc"}, 64'(done), 64'd0);
      end

      // Back-to-back: new start in the DONE cycle
      start_op(OP_MUL, 32'h7, 32'hFFFFFFFD);
      wait_done(lat, bcnt, ovl);
      check("b2b_first", 64'(result), 64'hFFFFFFEB);
      start_op(OP_MUL, 32'd3, 32'd4);
      check("b2b_done_drop", 64'(done), 64'd0);
      check("b2b_busy", 64'(busy), 64'd1);
      wait_done(lat, bcnt, ovl);
      check("b2b_result", 64'(result), 64'd12);
      check("b2b_lat", 64'(lat), 64'd33);
      @(posedge clk); #1;

      // Kill when counter reaches 10 (22 edges after the start edge)
      start_op(OP_DIVU, 32'd100, 32'd7);
      repeat (22) @(posedge clk);
      #1 kill = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0;
      check("kill_busy", 64'(busy), 64'd0);
      check("kill_done", 64'(done), 64'd0);
      count_dones(40, nd);
      check("kill_no_done", 64'(nd), 64'd0);
      check("kill_result_kept", 64'(result), 64'd12);

      // Operands changed during CALC have no effect
      start_op(OP_DIVU, 32'd100, 32'd7);
      a = 32'h0000FFFF; b = 32'd3; op = OP_MUL;
      wait_done(lat, bcnt, ovl);
      check("latch_result", 64'(result), 64'd14);
      check("latch_lat", 64'(lat), 64'd33);
      @(posedge clk); #1;

      // Start while busy is ignored
      start_op(OP_DIVU, 32'd100, 32'd7);
      repeat (5) @(posedge clk);
      #1 start = 1'b1; op = OP_MUL; a = 32'd3; b = 32'd4;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(lat, bcnt, ovl);
      check("ignore_result", 64'(result), 64'd14);
      check("ignore_lat", 64'(lat), 64'd27);
      count_dones(40, nd);
      check("ignore_one_done", 64'(nd), 64'd0);

      // Async reset mid-MUL
      start_op(OP_MUL, 32'd5, 32'd6);
      repeat (10) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("midrst_busy",   64'(busy),   64'd0);
      check("midrst_done",   64'(done),   64'd0);
      check("midrst_result", 64'(result), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      count_dones(40, nd);
      check("midrst_no_done", 64'(nd), 64'd0);
      check("midrst_idle", 64'(busy), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
